// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Request-side controller for an 8-bit combinational ALU. Accepts one
// operation at a time on a valid/ready request channel and drives registered
// operands/select into the ALU. It holds that operation for one cycle so the
// ALU can settle, then captures the result and flags. The captured values
// are returned on a valid/ready response channel. A chain register keeps the
// last committed result so it can be used as operand A (accumulate). The block
// also keeps a sticky overflow bit and a saturating count of legal issued ops.
module alu_op_sequencer #(
   parameter int W     = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   // request channel
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [W-1:0]     req_a,
   input  logic [W-1:0]     req_b,
   input  logic [3:0]       req_shift,
   input  logic             req_chain,
   // ALU drive (registered)
   output logic [W-1:0]     alu_a,
   output logic [W-1:0]     alu_b,
   output logic [2:0]       alu_s,
   output logic [3:0]       alu_shift,
   // ALU result (combinational from alu_*)
   input  logic [W-1:0]     alu_y,
   input  logic             alu_cero,
   input  logic             alu_carry,
   input  logic             alu_ovf,
   // response channel
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [W-1:0]     rsp_y,
   output logic [3:0]       rsp_flags,
   // status
   output logic             sticky_ovf,
   input  logic             clr_sticky,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [2:0]       OP_LAST_LEGAL = 3'd5;
   localparam logic [3:0]       FLAGS_ERR     = 4'b1000;
   localparam logic [CNT_W-1:0] CNT_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX       = {CNT_W{1'b1}};

   state_t           r_state;
   logic             r_req_ready;
   logic             r_rsp_valid;
   logic [W-1:0]     r_alu_a;
   logic [W-1:0]     r_alu_b;
   logic [2:0]       r_alu_s;
   logic [3:0]       r_alu_shift;
   logic [W-1:0]     r_rsp_y;
   logic [3:0]       r_rsp_flags;
   logic [W-1:0]     r_acc;
   logic             r_sticky_ovf;
   logic [CNT_W-1:0] r_op_count;

   logic             w_req_fire;
   logic             w_op_legal;
   logic             w_rsp_fire;

   // Handshake qualifiers; req_ready/rsp_valid are registered so these only
   // look at the current state's outputs.
   assign w_req_fire = req_valid & r_req_ready;
   assign w_op_legal = (req_op <= OP_LAST_LEGAL);
   assign w_rsp_fire = r_rsp_valid & rsp_ready;

   // Sequencer FSM with all outputs, chain register and status registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_req_ready  <= 1'b1;
         r_rsp_valid  <= 1'b0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_s      <= '0;
         r_alu_shift  <= '0;
         r_rsp_y      <= '0;
         r_rsp_flags  <= '0;
         r_acc        <= '0;
         r_sticky_ovf <= 1'b0;
         r_op_count   <= '0;
      end else begin
         // Clear first so that an overflow capture later in this block wins.
         if (clr_sticky) begin
            r_sticky_ovf <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (w_req_fire) begin
                  r_req_ready <= 1'b0;
                  if (w_op_legal) begin
                     // ALU inputs change only here, so they stay quiet between ops.
                     r_alu_a     <= req_chain ? r_acc : req_a;
                     r_alu_b     <= req_b;
                     r_alu_s     <= req_op;
                     r_alu_shift <= req_shift;
                     if (r_op_count != CNT_MAX) begin
                        r_op_count <= r_op_count + CNT_ONE;
                     end
                     r_state <= S_EXEC;
                  end else begin
                     // Illegal select: answer immediately, leave ALU and acc alone.
                     r_rsp_y     <= '0;
                     r_rsp_flags <= FLAGS_ERR;
                     r_rsp_valid <= 1'b1;
                     r_state     <= S_RESP;
                  end
               end
            end

            S_EXEC: begin
               // ALU has had a full cycle to settle on the registered inputs.
               r_rsp_y     <= alu_y;
               r_rsp_flags <= {1'b0, alu_ovf, alu_carry, alu_cero};
               r_acc       <= alu_y;
               if (alu_ovf) begin
                  r_sticky_ovf <= 1'b1;
               end
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
            end

            S_RESP: begin
               if (w_rsp_fire) begin
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end

            default: begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b1;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = r_req_ready;
   assign rsp_valid  = r_rsp_valid;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_s      = r_alu_s;
   assign alu_shift  = r_alu_shift;
   assign rsp_y      = r_rsp_y;
   assign rsp_flags  = r_rsp_flags;
   assign sticky_ovf = r_sticky_ovf;
   assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Directed bench for alu_op_sequencer with a behavioural 8-bit ALU attached.
// The counter width is reduced so saturation is reachable in a short run.
module tb_alu_op_sequencer;

   localparam int W     = 8;
   localparam int CNT_W = 3;

   logic             clk;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_op;
   logic [W-1:0]     req_a;
   logic [W-1:0]     req_b;
   logic [3:0]       req_shift;
   logic             req_chain;
   logic [W-1:0]     alu_a;
   logic [W-1:0]     alu_b;
   logic [2:0]       alu_s;
   logic [3:0]       alu_shift;
   logic [W-1:0]     alu_y;
   logic             alu_cero;
   logic             alu_carry;
   logic             alu_ovf;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [W-1:0]     rsp_y;
   logic [3:0]       rsp_flags;
   logic             sticky_ovf;
   logic             clr_sticky;
   logic [CNT_W-1:0] op_count;

   int n_checks = 0;
   int n_errors = 0;
   int exp_cnt  = 0;

   alu_op_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_shift  (req_shift),
      .req_chain  (req_chain),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_s      (alu_s),
      .alu_shift  (alu_shift),
      .alu_y      (alu_y),
      .alu_cero   (alu_cero),
      .alu_carry  (alu_carry),
      .alu_ovf    (alu_ovf),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_y      (rsp_y),
      .rsp_flags  (rsp_flags),
      .sticky_ovf (sticky_ovf),
      .clr_sticky (clr_sticky),
      .op_count   (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: carry is carry-out for add, borrow for sub.
   logic [8:0] t_sum;
   logic [8:0] t_dif;
   always_comb begin
      t_sum     = {1'b0, alu_a} + {1'b0, alu_b};
      t_dif     = {1'b0, alu_a} - {1'b0, alu_b};
      alu_y     = 8'h00;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (alu_s)
         3'd0: begin
            alu_y     = t_sum[7:0];
            alu_carry = t_sum[8];
            alu_ovf   = (alu_a[7] == alu_b[7]) && (t_sum[7] != alu_a[7]);
         end
         3'd1: begin
            alu_y     = t_dif[7:0];
            alu_carry = t_dif[8];
            alu_ovf   = (alu_a[7] != alu_b[7]) && (t_dif[7] != alu_a[7]);
         end
         3'd2: alu_y = alu_a & alu_b;
         3'd3: alu_y = alu_a | alu_b;
         3'd4: alu_y = t_sum[7:0] << alu_shift;
         3'd5: alu_y = t_sum[7:0] >> alu_shift;
         default: alu_y = 8'h00;
      endcase
      alu_cero = (alu_y == 8'h00);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one request from a negedge, measure latency in negedges until
   // rsp_valid, and check the response. Leaves the response pending.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] sh, input logic ch,
                         input logic clr_exec, input logic [7:0] exp_y,
                         input logic [3:0] exp_fl, input int exp_lat);
      int lat;
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_shift = sh;
      req_chain = ch;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      clr_sticky = clr_exec;
      if (op <= 3'd5 && exp_cnt < 7) exp_cnt++;
      lat = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         lat++;
         if (lat >= 2) clr_sticky = 1'b0;
         if (rsp_valid) break;
      end
      clr_sticky = 1'b0;
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_y"}, 32'(rsp_y), 32'(exp_y));
      check({tag, "_flags"}, 32'(rsp_flags), 32'(exp_fl));
      check({tag, "_op_count"}, 32'(op_count), 32'(exp_cnt));
      $display("txn %s op=%0d a=%02h b=%02h sh=%0d chain=%0b -> y=%02h flags=%04b lat=%0d cnt=%0d",
               tag, op, a, b, sh, ch, rsp_y, rsp_flags, lat, op_count);
   endtask

   // Accept the pending response; returns at a negedge with the DUT idle.
   task automatic consume();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_clr();
      clr_sticky = 1'b1;
      @(posedge clk);
      #1;
      clr_sticky = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_op     = 3'd0;
      req_a      = 8'h00;
      req_b      = 8'h00;
      req_shift  = 4'd0;
      req_chain  = 1'b0;
      rsp_ready  = 1'b0;
      clr_sticky = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_alu_a", 32'(alu_a), 32'd0);
      check("rst_alu_b", 32'(alu_b), 32'd0);
      check("rst_alu_s", 32'(alu_s), 32'd0);
      check("rst_alu_shift", 32'(alu_shift), 32'd0);
      check("rst_rsp_y", 32'(rsp_y), 32'd0);
      check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
      check("rst_sticky", 32'(sticky_ovf), 32'd0);
      check("rst_op_count", 32'(op_count), 32'd0);

      // Signed overflow on add, sticky set
      run_op("add_ovf", 3'd0, 8'h7F, 8'h01, 4'd0, 1'b0, 1'b0, 8'h80, 4'b0100, 2);
      check("add_ovf_sticky", 32'(sticky_ovf), 32'd1);
      check("add_ovf_alu_a", 32'(alu_a), 32'h7F);
      consume();
      pulse_clr();
      check("clr_alone_sticky", 32'(sticky_ovf), 32'd0);

      // Zero result, then chained subtract ignoring req_a
      run_op("sub_zero", 3'd1, 8'h05, 8'h05, 4'd0, 1'b0, 1'b0, 8'h00, 4'b0001, 2);
      consume();
      run_op("sub_chain", 3'd1, 8'h55, 8'h01, 4'd0, 1'b1, 1'b0, 8'hFF, 4'b0010, 2);
      check("sub_chain_alu_a", 32'(alu_a), 32'h00);
      consume();

      // Illegal op: immediate error response, ALU and acc untouched
      run_op("illegal6", 3'd6, 8'h12, 8'h34, 4'd0, 1'b0, 1'b0, 8'h00, 4'b1000, 1);
      check("illegal_alu_s", 32'(alu_s), 32'd1);
      check("illegal_alu_a", 32'(alu_a), 32'h00);
      consume();
      run_op("chain_after_ill", 3'd0, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 8'hFF, 4'b0000, 2);
      consume();

      // Back-pressure: response held stable for 5 cycles, new requests ignored
      run_op("add_carry", 3'd0, 8'hFF, 8'h01, 4'd0, 1'b0, 1'b0, 8'h00, 4'b0011, 2);
      req_valid = 1'b1;
      req_op    = 3'd2;
      req_a     = 8'h11;
      req_b     = 8'h22;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
         check("hold_rsp_y", 32'(rsp_y), 32'h00);
         check("hold_rsp_flags", 32'(rsp_flags), 32'b0011);
         check("hold_req_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      check("hold_alu_a", 32'(alu_a), 32'hFF);
      check("hold_alu_s", 32'(alu_s), 32'd0);
      consume();

      // Logic and shift-of-sum selects
      run_op("and", 3'd2, 8'hF0, 8'h3C, 4'd0, 1'b0, 1'b0, 8'h30, 4'b0000, 2);
      consume();
      run_op("or", 3'd3, 8'h0F, 8'h30, 4'd0, 1'b0, 1'b0, 8'h3F, 4'b0000, 2);
      consume();
      run_op("shl", 3'd4, 8'h03, 8'h01, 4'd2, 1'b0, 1'b0, 8'h10, 4'b0000, 2);
      consume();
      run_op("shr", 3'd5, 8'h80, 8'h00, 4'd3, 1'b0, 1'b0, 8'h10, 4'b0000, 2);
      check("shr_alu_shift", 32'(alu_shift), 32'd3);
      consume();

      // Clear coincident with overflow capture: set wins
      run_op("ovf_clr", 3'd0, 8'h80, 8'h80, 4'd0, 1'b0, 1'b1, 8'h00, 4'b0111, 2);
      check("ovf_clr_sticky", 32'(sticky_ovf), 32'd1);
      consume();
      pulse_clr();
      check("clr_after_sticky", 32'(sticky_ovf), 32'd0);

      // Reset during EXEC aborts the op
      run_op("add_ovf2", 3'd0, 8'h40, 8'h40, 4'd0, 1'b0, 1'b0, 8'h80, 4'b0100, 2);
      check("add_ovf2_sticky", 32'(sticky_ovf), 32'd1);
      consume();
      req_valid = 1'b1;
      req_op    = 3'd0;
      req_a     = 8'h01;
      req_b     = 8'h01;
      req_chain = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst_n     = 1'b0;
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      exp_cnt = 0;
      @(negedge clk);
      check("rstx_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rstx_req_ready", 32'(req_ready), 32'd1);
      check("rstx_op_count", 32'(op_count), 32'd0);
      check("rstx_sticky", 32'(sticky_ovf), 32'd0);
      check("rstx_alu_a", 32'(alu_a), 32'd0);
      repeat (3) @(negedge clk);
      check("rstx_no_rsp", 32'(rsp_valid), 32'd0);
      $display("txn reset_in_exec rsp_valid=%0b op_count=%0d sticky=%0b", rsp_valid, op_count, sticky_ovf);

      // Counter saturation (3-bit counter saturates at 7)
      for (int i = 0; i < 8; i++) begin
         run_op("sat_add", 3'd0, 8'h01, 8'h01, 4'd0, 1'b0, 1'b0, 8'h02, 4'b0000, 2);
         consume();
      end
      check("sat_op_count", 32'(op_count), 32'd7);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Hard bound in case the stimulus ever stalls
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
